// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit/group propagate-generate; stage 2 resolves carries and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0;
  logic [NG-1:0]    s1_gp, s1_gg;

  logic             s2_ready, accept, s1_to_s2;
  logic [WIDTH-1:0] bx, p_in, g_in;
  logic             c0_in;
  logic [NG-1:0]    gp_in, gg_in;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;
  assign accept   = in_valid & in_ready;
  assign s1_to_s2 = s1_valid & s2_ready;

  always_comb begin
    bx    = sub ? ~b : b;
    c0_in = sub ? ~cin : cin;
    p_in  = a ^ bx;
    g_in  = a & bx;
    gp_in = '0;
    gg_in = '0;
    for (int j = 0; j < NG; j++) begin
      gp_in[j] = &p_in[4*j +: 4];
      gg_in[j] = g_in[4*j+3]
               | (p_in[4*j+3] & g_in[4*j+2])
               | (p_in[4*j+3] & p_in[4*j+2] & g_in[4*j+1])
               | (&p_in[4*j+1 +: 3] & g_in[4*j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_c0    <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_p     <= p_in;
        s1_g     <= g_in;
        s1_c0    <= c0_in;
        s1_gp    <= gp_in;
        s1_gg    <= gg_in;
      end else if (s1_to_s2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  logic [NG:0]      cg;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_nxt;
  logic             run_p, acc;

  // Each group carry is an OR of products over GG/GP/c0, never chained through cg[j].
  always_comb begin
    cg    = '0;
    cg[0] = s1_c0;
    run_p = 1'b0;
    acc   = 1'b0;
    for (int j = 0; j < NG; j++) begin
      run_p = 1'b1;
      acc   = 1'b0;
      for (int k = j; k >= 0; k--) begin
        acc   = acc | (s1_gg[k] & run_p);
        run_p = run_p & s1_gp[k];
      end
      cg[j+1] = acc | (run_p & s1_c0);
    end
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = s1_g[4*j] | (s1_p[4*j] & cg[j]);
      c[4*j+2] = s1_g[4*j+1]
               | (s1_p[4*j+1] & s1_g[4*j])
               | (s1_p[4*j+1] & s1_p[4*j] & cg[j]);
      c[4*j+3] = s1_g[4*j+2]
               | (s1_p[4*j+2] & s1_g[4*j+1])
               | (s1_p[4*j+2] & s1_p[4*j+1] & s1_g[4*j])
               | (s1_p[4*j+2] & s1_p[4*j+1] & s1_p[4*j] & cg[j]);
    end
    c[WIDTH] = cg[NG];
    sum_nxt  = s1_p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (s1_to_s2) begin
        out_valid <= 1'b1;
        sum       <= sum_nxt;
        cout      <= c[WIDTH];
        ovf       <= c[WIDTH] ^ c[WIDTH-1];
        zero      <= ~|sum_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vector table, scoreboarded random traffic
// on 32-, 64- and 4-bit instances, back-pressure and mid-flight reset sequences.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv, ir, ov, ordy, ci, sb, co, of, zf;
  logic [31:0] a, b, s;

  logic        iv_w, ir64, ir4, ov64, ov4, or_w, ci_w, sb_w;
  logic        co64, of64, z64, co4, of4, z4;
  logic [63:0] a_w, b_w, s64;
  logic [3:0]  s4;

  pipelined_cla_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .sum(s),
    .cout(co), .ovf(of), .zero(zf));

  pipelined_cla_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir64), .a(a_w), .b(b_w),
    .cin(ci_w), .sub(sb_w), .out_valid(ov64), .out_ready(or_w), .sum(s64),
    .cout(co64), .ovf(of64), .zero(z64));

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir4), .a(a_w[3:0]), .b(b_w[3:0]),
    .cin(ci_w), .sub(sb_w), .out_valid(ov4), .out_ready(or_w), .sum(s4),
    .cout(co4), .ovf(of4), .zero(z4));

  int errors = 0;
  int checks = 0;
  res_t q32[$];
  res_t q64[$];
  res_t q4[$];
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: exact signed/unsigned arithmetic in a wider word.
  function automatic res_t ref_model(input logic [63:0] av, input logic [63:0] bv,
                                     input logic cv, input logic sv, input int w);
    res_t r;
    logic [63:0] mask;
    logic [67:0] ua, ub, uc, ur;
    logic signed [67:0] sa, sbv, sc, sr, lim;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ua  = {4'b0, av & mask};
    ub  = {4'b0, bv & mask};
    uc  = {67'b0, cv};
    sa  = signed'(ua);
    sbv = signed'(ub);
    sc  = signed'(uc);
    lim = 68'sd1 <<< (w - 1);
    if (ua[w-1]) sa = sa - (lim <<< 1);
    if (ub[w-1]) sbv = sbv - (lim <<< 1);
    if (sv) begin
      ur = ua - ub - uc;
      sr = sa - sbv - sc;
      r.cout = (ua >= ub + uc);
    end else begin
      ur = ua + ub + uc;
      sr = sa + sbv + sc;
      r.cout = ur[w];
    end
    r.sum  = ur[63:0] & mask;
    r.zero = (r.sum == 64'd0);
    r.ovf  = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // Scoreboard monitor: push on predicted accept, pop on output handshake.
  always @(negedge clk) begin
    res_t r;
    if (rst_n) begin
      if (iv && ir) q32.push_back(ref_model({32'b0, a}, {32'b0, b}, ci, sb, 32));
      if (ov && ordy) begin
        if (q32.size() == 0) chk("sb32_unexpected_output", 64'd1, 64'd0);
        else begin
          r = q32.pop_front();
          chk("sb32_sum", {32'b0, s}, r.sum);
          chk("sb32_cout", co, r.cout);
          chk("sb32_ovf", of, r.ovf);
          chk("sb32_zero", zf, r.zero);
        end
      end
      if (iv_w && ir64) begin
        q64.push_back(ref_model(a_w, b_w, ci_w, sb_w, 64));
        q4.push_back(ref_model(a_w, b_w, ci_w, sb_w, 4));
      end
      if (ov64 && or_w) begin
        if (q64.size() == 0) chk("sbw_unexpected_output", 64'd1, 64'd0);
        else begin
          r = q64.pop_front();
          chk("sb64_sum", s64, r.sum);
          chk("sb64_cout", co64, r.cout);
          chk("sb64_ovf", of64, r.ovf);
          chk("sb64_zero", z64, r.zero);
          r = q4.pop_front();
          chk("sb4_valid", ov4, 1'b1);
          chk("sb4_sum", {60'b0, s4}, r.sum);
          chk("sb4_cout", co4, r.cout);
          chk("sb4_ovf", of4, r.ovf);
          chk("sb4_zero", z4, r.zero);
        end
      end
    end
  end

  task automatic send32(input logic [31:0] aa, input logic [31:0] bb,
                        input logic cc, input logic ss, output int waits);
    int n;
    n = 0;
    a = aa; b = bb; ci = cc; sb = ss; iv = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ir && n < 200);
    if (!ir) chk("send32_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 iv = 1'b0;
    waits = n - 1;
  endtask

  task automatic wait_empty32(input string name);
    int n;
    n = 0;
    while (q32.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, q32.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, n;
    bit wdone;
    vt[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[4] = '{32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vt[5] = '{32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
    vt[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
    vt[8] = '{32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
    iv_w = 1'b0; or_w = 1'b1; a_w = '0; b_w = '0; ci_w = 1'b0; sb_w = 1'b0;
    wdone = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", ov, 1'b0);
    chk("reset_sum", s, 32'h0);
    chk("reset_flags", {co, of, zf}, 3'b000);
    chk("reset_in_ready", ir, 1'b1);
    #2 rst_n = 1'b1;

    // Directed vectors with explicit latency checks
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 a = vt[i].a; b = vt[i].b; ci = vt[i].cin; sb = vt[i].sub; iv = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), ir, 1'b1);
      @(posedge clk);
      #1 iv = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_not_early", i), ov, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), ov, 1'b1);
      chk($sformatf("vec%0d_sum", i), s, vt[i].sum);
      chk($sformatf("vec%0d_cout", i), co, vt[i].cout);
      chk($sformatf("vec%0d_ovf", i), of, vt[i].ovf);
      chk($sformatf("vec%0d_zero", i), zf, vt[i].zero);
    end
    wait_empty32("vec_drain");

    // Back-to-back random ops at full throughput
    @(posedge clk);
    #1 stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      stalls += w;
    end
    chk("b2b_stalls", stalls, 0);
    wait_empty32("b2b_drain");

    // Back-pressure: three offers, only two fit
    @(posedge clk);
    #1 ordy = 1'b0;
    fork
      begin
        send32(32'h10, 32'h20, 1'b0, 1'b0, w);
        send32(32'h100, 32'h1, 1'b1, 1'b1, w);
        send32(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, w);
      end
    join_none
    repeat (6) @(negedge clk);
    chk("bp_in_ready_low", ir, 1'b0);
    chk("bp_held_count", q32.size(), 2);
    chk("bp_third_pending", iv, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", ov, 1'b1);
      chk("bp_sum_stable", s, 32'h30);
      chk("bp_flags_stable", {co, of, zf}, 3'b000);
    end
    @(posedge clk);
    #1 ordy = 1'b1;
    wait fork;
    wait_empty32("bp_drain");

    // Reset with two ops in flight
    @(posedge clk);
    #1 ordy = 1'b0;
    send32(32'h1234, 32'h1, 1'b0, 1'b0, w);
    send32(32'h5678, 32'h1, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("rst_full_in_ready", ir, 1'b0);
    chk("rst_full_out_valid", ov, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", ov, 1'b0);
    chk("rst_async_sum", s, 32'h0);
    chk("rst_async_flags", {co, of, zf}, 3'b000);
    chk("rst_async_in_ready", ir, 1'b1);
    q32.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", ov, 1'b0);
    end

    // Random valid/ready traffic on the 64- and 4-bit instances
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            iv_w = 1'b0;
            @(posedge clk);
            #1;
          end
          case ($urandom_range(0, 7))
            0: a_w = {64{1'b1}};
            1: a_w = 64'h0;
            2: a_w = 64'h8000_0000_0000_0000;
            default: a_w = {$urandom, $urandom};
          endcase
          case ($urandom_range(0, 7))
            0: b_w = {64{1'b1}};
            1: b_w = 64'h0;
            2: b_w = 64'h7FFF_FFFF_FFFF_FFFF;
            default: b_w = {$urandom, $urandom};
          endcase
          ci_w = 1'($urandom_range(0, 1));
          sb_w = 1'($urandom_range(0, 1));
          iv_w = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!ir64 && n < 200);
          if (!ir64) chk("wide_send_timeout", 64'd1, 64'd0);
          @(posedge clk);
          #1 iv_w = 1'b0;
        end
        wdone = 1'b1;
      end
      begin
        while (!wdone) begin
          @(posedge clk);
          #1 or_w = ($urandom_range(0, 3) != 0);
        end
      end
    join
    or_w = 1'b1;
    n = 0;
    while (q64.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wide_drain", q64.size(), 0);
    chk("wide_in_ready_idle", {ir64, ir4}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
